// File: rtl/ecc_pkg.sv
// Shared SECDED definitions for the 32-bit codeword (26 data bits, Hamming positions 1..31 plus
// overall parity in bit 0): widths, status encoding and data-position helpers.
package ecc_pkg;

  localparam int ECC_DATA_W = 26;
  localparam int ECC_CODE_W = 32;
  localparam int ECC_SYN_W  = 5;

  typedef enum logic [1:0] {
    ECC_OK     = 2'b00,
    ECC_CORR   = 2'b01,
    ECC_UNCORR = 2'b10
  } ecc_status_e;

  // Every non-power-of-two position in ascending order; data bit i lives at ECC_DATA_POS[i].
  localparam logic [4:0] ECC_DATA_POS [ECC_DATA_W] = '{
    5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13,
    5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
    5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31
  };

  function automatic logic [ECC_DATA_W-1:0] ecc_extract(input logic [ECC_CODE_W-1:0] code);
    logic [ECC_DATA_W-1:0] data;
    data = '0;
    for (int i = 0; i < ECC_DATA_W; i++) begin
      data[i] = code[ECC_DATA_POS[i]];
    end
    return data;
  endfunction

  function automatic logic [ECC_CODE_W-1:0] ecc_insert(input logic [ECC_DATA_W-1:0] data);
    logic [ECC_CODE_W-1:0] code;
    code = '0;
    for (int i = 0; i < ECC_DATA_W; i++) begin
      code[ECC_DATA_POS[i]] = data[i];
    end
    return code;
  endfunction

endpackage

// File: rtl/ecc_secded_decoder_if.sv
// Stream pair of the SECDED decoder: codewords in (valid/ready), decoded results out (valid/ready).
interface ecc_secded_decoder_if
  import ecc_pkg::*;
#(
  parameter int TAG_W = 5
);

  logic                  in_valid;
  logic                  in_ready;
  logic [ECC_CODE_W-1:0] in_code;
  logic [TAG_W-1:0]      in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [ECC_DATA_W-1:0] out_data;
  logic [TAG_W-1:0]      out_tag;
  logic [1:0]            out_status;
  logic [ECC_SYN_W-1:0]  out_syndrome;

  modport master (
    output in_valid, in_code, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_status, out_syndrome
  );

  modport slave (
    input  in_valid, in_code, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_status, out_syndrome
  );

endinterface

// File: rtl/ecc_syndrome.sv
// Combinational Hamming syndrome and overall even parity of a 32-bit SECDED codeword; shared with
// the encoder-side self check.
module ecc_syndrome
  import ecc_pkg::*;
(
  input  logic [ECC_CODE_W-1:0] code,
  output logic [ECC_SYN_W-1:0]  syndrome,
  output logic                  parity
);

  always_comb begin
    syndrome = '0;
    for (int p = 1; p < ECC_CODE_W; p++) begin
      if (code[p]) syndrome = syndrome ^ ECC_SYN_W'(p);
    end
    parity = ^code;
  end

endmodule

// File: rtl/ecc_secded_decoder.sv
// Two-stage SECDED decoder with saturating event counters and a first-uncorrectable-word log.
// Optional ECC_SCRUB_EN adds a one-cycle scrub_valid/scrub_code pulse with each repaired codeword.
module ecc_secded_decoder
  import ecc_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int TAG_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  ecc_secded_decoder_if.slave   bus,
  input  logic                  cnt_clear,
  output logic [CNT_W-1:0]      corr_count,
  output logic [CNT_W-1:0]      uncorr_count,
  output logic                  log_valid,
  output logic [ECC_CODE_W-1:0] log_code,
  output logic [TAG_W-1:0]      log_tag
`ifdef ECC_SCRUB_EN
  ,
  output logic                  scrub_valid,
  output logic [ECC_CODE_W-1:0] scrub_code
`endif
);

  logic [ECC_SYN_W-1:0]  syn;
  logic                  par;
  logic                  in_ready;
  logic                  s2_adv;
  logic                  fire;
  logic [ECC_CODE_W-1:0] flip;
  logic [ECC_CODE_W-1:0] fixed;
  ecc_status_e           status;

  logic                  s1_valid_q, s1_valid_d;
  logic [ECC_CODE_W-1:0] s1_code_q, s1_code_d;
  logic [TAG_W-1:0]      s1_tag_q, s1_tag_d;
  logic [ECC_SYN_W-1:0]  s1_syn_q, s1_syn_d;
  logic                  s1_par_q, s1_par_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [ECC_DATA_W-1:0] s2_data_q, s2_data_d;
  logic [TAG_W-1:0]      s2_tag_q, s2_tag_d;
  ecc_status_e           s2_status_q, s2_status_d;
  logic [ECC_SYN_W-1:0]  s2_syn_q, s2_syn_d;
  logic [ECC_CODE_W-1:0] s2_code_q, s2_code_d;

  logic [CNT_W-1:0]      corr_count_q, corr_count_d;
  logic [CNT_W-1:0]      uncorr_count_q, uncorr_count_d;
  logic                  log_valid_q, log_valid_d;
  logic [ECC_CODE_W-1:0] log_code_q, log_code_d;
  logic [TAG_W-1:0]      log_tag_q, log_tag_d;

  ecc_syndrome u_syndrome (
    .code     (bus.in_code),
    .syndrome (syn),
    .parity   (par)
  );

  always_comb begin
    s2_adv   = !s2_valid_q || bus.out_ready;
    in_ready = !s1_valid_q || s2_adv;
    fire     = s2_valid_q && bus.out_ready;

    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_tag_d   = s1_tag_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    if (in_ready) s1_valid_d = bus.in_valid;
    if (in_ready && bus.in_valid) begin
      s1_code_d = bus.in_code;
      s1_tag_d  = bus.in_tag;
      s1_syn_d  = syn;
      s1_par_d  = par;
    end

    // A set overall parity means an odd error count: repair it, bit 0 when the syndrome is zero.
    flip = '0;
    if (s1_par_q) flip = (s1_syn_q == '0) ? 32'd1 : (32'd1 << s1_syn_q);
    fixed = s1_code_q ^ flip;
    if (s1_par_q)              status = ECC_CORR;
    else if (s1_syn_q != '0)   status = ECC_UNCORR;
    else                       status = ECC_OK;

    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_tag_d    = s2_tag_q;
    s2_status_d = s2_status_q;
    s2_syn_d    = s2_syn_q;
    s2_code_d   = s2_code_q;
    if (s2_adv) s2_valid_d = s1_valid_q;
    if (s2_adv && s1_valid_q) begin
      s2_data_d   = ecc_extract(fixed);
      s2_tag_d    = s1_tag_q;
      s2_status_d = status;
      s2_syn_d    = s1_syn_q;
      s2_code_d   = s1_code_q;
    end

    corr_count_d   = corr_count_q;
    uncorr_count_d = uncorr_count_q;
    log_valid_d    = log_valid_q;
    log_code_d     = log_code_q;
    log_tag_d      = log_tag_q;
    // Clearing wins over any event retiring in the same cycle.
    if (cnt_clear) begin
      corr_count_d   = '0;
      uncorr_count_d = '0;
      log_valid_d    = 1'b0;
      log_code_d     = '0;
      log_tag_d      = '0;
    end else if (fire) begin
      if (s2_status_q == ECC_CORR && corr_count_q != '1)
        corr_count_d = corr_count_q + CNT_W'(1);
      if (s2_status_q == ECC_UNCORR && uncorr_count_q != '1)
        uncorr_count_d = uncorr_count_q + CNT_W'(1);
      if (s2_status_q == ECC_UNCORR && !log_valid_q) begin
        log_valid_d = 1'b1;
        log_code_d  = s2_code_q;
        log_tag_d   = s2_tag_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s1_code_q      <= '0;
      s1_tag_q       <= '0;
      s1_syn_q       <= '0;
      s1_par_q       <= 1'b0;
      s2_valid_q     <= 1'b0;
      s2_data_q      <= '0;
      s2_tag_q       <= '0;
      s2_status_q    <= ECC_OK;
      s2_syn_q       <= '0;
      s2_code_q      <= '0;
      corr_count_q   <= '0;
      uncorr_count_q <= '0;
      log_valid_q    <= 1'b0;
      log_code_q     <= '0;
      log_tag_q      <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_code_q      <= s1_code_d;
      s1_tag_q       <= s1_tag_d;
      s1_syn_q       <= s1_syn_d;
      s1_par_q       <= s1_par_d;
      s2_valid_q     <= s2_valid_d;
      s2_data_q      <= s2_data_d;
      s2_tag_q       <= s2_tag_d;
      s2_status_q    <= s2_status_d;
      s2_syn_q       <= s2_syn_d;
      s2_code_q      <= s2_code_d;
      corr_count_q   <= corr_count_d;
      uncorr_count_q <= uncorr_count_d;
      log_valid_q    <= log_valid_d;
      log_code_q     <= log_code_d;
      log_tag_q      <= log_tag_d;
    end
  end

`ifdef ECC_SCRUB_EN
  logic [ECC_CODE_W-1:0] s2_fixed_q, s2_fixed_d;
  logic                  scrub_valid_q, scrub_valid_d;
  logic [ECC_CODE_W-1:0] scrub_code_q, scrub_code_d;

  always_comb begin
    s2_fixed_d    = (s2_adv && s1_valid_q) ? fixed : s2_fixed_q;
    scrub_valid_d = fire && (s2_status_q == ECC_CORR);
    scrub_code_d  = scrub_valid_d ? s2_fixed_q : scrub_code_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_fixed_q    <= '0;
      scrub_valid_q <= 1'b0;
      scrub_code_q  <= '0;
    end else begin
      s2_fixed_q    <= s2_fixed_d;
      scrub_valid_q <= scrub_valid_d;
      scrub_code_q  <= scrub_code_d;
    end
  end

  assign scrub_valid = scrub_valid_q;
  assign scrub_code  = scrub_code_q;
`endif

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = s2_valid_q;
  assign bus.out_data     = s2_data_q;
  assign bus.out_tag      = s2_tag_q;
  assign bus.out_status   = s2_status_q;
  assign bus.out_syndrome = s2_syn_q;
  assign corr_count       = corr_count_q;
  assign uncorr_count     = uncorr_count_q;
  assign log_valid        = log_valid_q;
  assign log_code         = log_code_q;
  assign log_tag          = log_tag_q;

endmodule

// File: tb/tb_ecc_secded_decoder.sv
// Directed scoreboard bench for ecc_secded_decoder (counter width 2 so saturation is reachable).
module tb_ecc_secded_decoder;

  localparam int CNT_W = 2;
  localparam int TAG_W = 5;
  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_CORR   = 2'b01;
  localparam logic [1:0] ST_UNCORR = 2'b10;

  typedef struct {
    logic [25:0]      data;
    logic [TAG_W-1:0] tag;
    logic [1:0]       status;
    logic [4:0]       syn;
    logic [31:0]      code;
    logic [31:0]      clean;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             cnt_clear;
  logic [CNT_W-1:0] corr_count;
  logic [CNT_W-1:0] uncorr_count;
  logic             log_valid;
  logic [31:0]      log_code;
  logic [TAG_W-1:0] log_tag;
`ifdef ECC_SCRUB_EN
  logic             scrub_valid;
  logic [31:0]      scrub_code;
  logic             scrub_pending;
  logic [31:0]      scrub_exp;
`endif

  exp_t             sb[$];
  int               n_assert;
  int               n_fail;
  logic [CNT_W-1:0] exp_corr;
  logic [CNT_W-1:0] exp_uncorr;
  logic             exp_log_valid;
  logic [31:0]      exp_log_code;
  logic [TAG_W-1:0] exp_log_tag;

  ecc_secded_decoder_if #(.TAG_W(TAG_W)) bus ();

  ecc_secded_decoder #(.CNT_W(CNT_W), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .cnt_clear    (cnt_clear),
    .corr_count   (corr_count),
    .uncorr_count (uncorr_count),
    .log_valid    (log_valid),
    .log_code     (log_code),
    .log_tag      (log_tag)
`ifdef ECC_SCRUB_EN
    ,
    .scrub_valid  (scrub_valid),
    .scrub_code   (scrub_code)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tbEncode(input logic [25:0] d);
    logic [31:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 5; b++) begin
      for (int p = 1; p < 32; p++) begin
        if (p[b] && p != (1 << b)) c[1 << b] = c[1 << b] ^ c[p];
      end
    end
    c[0] = ^c[31:1];
    return c;
  endfunction

  function automatic logic [25:0] tbExtract(input logic [31:0] c);
    logic [25:0] d;
    int k;
    d = '0;
    k = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p];
        k++;
      end
    end
    return d;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    checkValue("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkValue("out_data", 32'(bus.out_data), 32'(e.data));
      checkValue("out_tag", 32'(bus.out_tag), 32'(e.tag));
      checkValue("out_status", 32'(bus.out_status), 32'(e.status));
      checkValue("out_syndrome", 32'(bus.out_syndrome), 32'(e.syn));
      if (e.status == ST_CORR && exp_corr != '1) exp_corr = exp_corr + CNT_W'(1);
      if (e.status == ST_UNCORR && exp_uncorr != '1) exp_uncorr = exp_uncorr + CNT_W'(1);
      if (e.status == ST_UNCORR && !exp_log_valid) begin
        exp_log_valid = 1'b1;
        exp_log_code  = e.code;
        exp_log_tag   = e.tag;
      end
`ifdef ECC_SCRUB_EN
      if (e.status == ST_CORR) begin
        scrub_pending = 1'b1;
        scrub_exp     = e.clean;
      end
`endif
    end
  endtask

  task automatic monitorLoop();
    forever begin
      @(negedge clk);
      if (!rst) begin
`ifdef ECC_SCRUB_EN
        checkValue("scrub_valid", 32'(scrub_valid), 32'(scrub_pending));
        if (scrub_pending) checkValue("scrub_code", scrub_code, scrub_exp);
        scrub_pending = 1'b0;
`endif
        if (bus.out_valid && bus.out_ready) checkOutput();
      end
    end
  endtask

  task automatic prepWord(input logic [25:0] data, input int e0, input int e1,
                          input logic [TAG_W-1:0] tag);
    exp_t e;
    e.clean = tbEncode(data);
    e.code  = e.clean;
    if (e0 >= 0) e.code[e0] = ~e.code[e0];
    if (e1 >= 0) e.code[e1] = ~e.code[e1];
    e.tag = tag;
    e.syn = 5'((e0 > 0 ? e0 : 0) ^ (e1 > 0 ? e1 : 0));
    if (e0 < 0) begin
      e.status = ST_OK;
      e.data   = data;
    end else if (e1 < 0) begin
      e.status = ST_CORR;
      e.data   = data;
    end else begin
      e.status = ST_UNCORR;
      e.data   = tbExtract(e.code);
    end
    bus.in_valid = 1'b1;
    bus.in_code  = e.code;
    bus.in_tag   = tag;
    sb.push_back(e);
  endtask

  task automatic waitAccept();
    int cycles;
    cycles = 0;
    @(negedge clk);
    while (!bus.in_ready && cycles < 50) begin
      cycles++;
      @(negedge clk);
    end
    checkValue("in_ready_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [25:0] data, input int e0, input int e1,
                               input logic [TAG_W-1:0] tag);
    prepWord(data, e0, e1, tag);
    waitAccept();
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkCounters(input string name);
    @(negedge clk);
    checkValue({name, "_corr"}, 32'(corr_count), 32'(exp_corr));
    checkValue({name, "_uncorr"}, 32'(uncorr_count), 32'(exp_uncorr));
    checkValue({name, "_log_valid"}, 32'(log_valid), 32'(exp_log_valid));
    checkValue({name, "_log_code"}, log_code, exp_log_code);
    checkValue({name, "_log_tag"}, 32'(log_tag), 32'(exp_log_tag));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e0;
    int e1;
    int mode;
    n_assert      = 0;
    n_fail        = 0;
    exp_corr      = '0;
    exp_uncorr    = '0;
    exp_log_valid = 1'b0;
    exp_log_code  = '0;
    exp_log_tag   = '0;
`ifdef ECC_SCRUB_EN
    scrub_pending = 1'b0;
    scrub_exp     = '0;
`endif
    rst           = 1'b1;
    cnt_clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    fork
      monitorLoop();
      begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
      end
    join_none

    repeat (3) @(negedge clk);
    checkValue("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkValue("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkCounters("rst");
    rst = 1'b0;

    $display("[TB] clean zero word");
    applyStimulus(26'h0, -1, -1, 5'd3);
    idle(4);
    checkCounters("clean");

    $display("[TB] single errors at bit 5 and at the overall parity bit");
    applyStimulus(26'h0, 5, -1, 5'd1);
    idle(4);
    checkCounters("corr_bit5");
    applyStimulus(26'h0, 0, -1, 5'd2);
    idle(4);
    checkCounters("corr_bit0");

    $display("[TB] double errors, log keeps the first");
    applyStimulus(26'h0, 3, 5, 5'd4);
    idle(4);
    checkCounters("uncorr_first");
    checkValue("log_code_first", log_code, 32'h0000_0028);
    applyStimulus(26'h155_5555, 7, 20, 5'd9);
    idle(4);
    checkCounters("uncorr_second");

    $display("[TB] mixed back-to-back words");
    for (int i = 0; i < 8; i++) begin
      mode = $urandom_range(0, 2);
      e0 = (mode > 0) ? $urandom_range(0, 31) : -1;
      e1 = (mode == 2) ? (e0 + $urandom_range(1, 31)) % 32 : -1;
      applyStimulus(26'($urandom), e0, e1, 5'(i + 16));
    end
    idle(5);
    checkCounters("mixed");

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    applyStimulus(26'h3ff_0001, -1, -1, 5'd10);
    applyStimulus(26'h000_fffe, 12, -1, 5'd11);
    prepWord(26'h2aa_aaaa, -1, -1, 5'd12);
    repeat (5) begin
      @(negedge clk);
      checkValue("bp_in_ready", 32'(bus.in_ready), 32'd0);
      checkValue("bp_hold_tag", 32'(bus.out_tag), 32'd10);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    waitAccept();
    idle(5);
    checkValue("bp_drained", 32'(sb.size()), 32'd0);

    $display("[TB] clear and saturation");
    cnt_clear = 1'b1;
    @(posedge clk);
    #1;
    cnt_clear     = 1'b0;
    exp_corr      = '0;
    exp_uncorr    = '0;
    exp_log_valid = 1'b0;
    exp_log_code  = '0;
    exp_log_tag   = '0;
    checkCounters("cleared");
    for (int i = 0; i < 5; i++) applyStimulus(26'($urandom), 1 + i * 6, -1, 5'(i));
    idle(5);
    checkCounters("saturated");
    checkValue("corr_sat_value", 32'(corr_count), 32'd3);

    $display("[TB] reset mid-stream");
    applyStimulus(26'h1234567, -1, -1, 5'd20);
    applyStimulus(26'h0abcdef, 9, -1, 5'd21);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    sb.delete();
    exp_corr      = '0;
    exp_uncorr    = '0;
    exp_log_valid = 1'b0;
    exp_log_code  = '0;
    exp_log_tag   = '0;
    #1;
    checkValue("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkValue("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    checkValue("mid_rst_out_tag", 32'(bus.out_tag), 32'd0);
    checkValue("mid_rst_out_status", 32'(bus.out_status), 32'd0);
    checkValue("mid_rst_out_syndrome", 32'(bus.out_syndrome), 32'd0);
    checkCounters("mid_rst");
    idle(2);
    rst = 1'b0;
    idle(2);
    checkValue("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    applyStimulus(26'h0f0f0f0, 30, -1, 5'd7);
    idle(5);
    checkCounters("post_rst");
    checkValue("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
